// File: rtl/shift_reg_seq.sv
// Sequencer for the universal shift register: parallel-loads a word, then shifts it out SIZE times.
// Optional SHIFT_REG_SEQ_PAUSE_EN adds a pause input that freezes shifting while high.
module shift_reg_seq #(
    parameter int unsigned SIZE = 8,
    parameter int unsigned DIV  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SIZE-1:0]           s_data,
    input  logic                      s_dir,
`ifdef SHIFT_REG_SEQ_PAUSE_EN
    input  logic                      pause,
`endif
    output logic [1:0]                mode,
    output logic [SIZE-1:0]           prl_out,
    output logic [$clog2(SIZE+1)-1:0] bit_cnt,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CNT_W = $clog2(SIZE + 1);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SIZE - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [SIZE-1:0]   prl_q, prl_d;
    logic              dir_q, dir_d;
    logic              stall_c;

`ifdef SHIFT_REG_SEQ_PAUSE_EN
    assign stall_c = pause;
`else
    assign stall_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: divider, shift counter, captured word and direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            bit_q <= '0;
            prl_q <= '0;
            dir_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
            prl_q <= prl_d;
            dir_q <= dir_d;
        end
    end

    // Next-state and output decode; mode is only non-zero in LOAD and on SHIFT tick cycles
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        prl_d   = prl_q;
        dir_d   = dir_q;
        mode    = MODE_HOLD;
        s_ready = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                busy    = 1'b0;
                s_ready = 1'b1;
                if (s_valid) begin
                    prl_d   = s_data;
                    dir_d   = s_dir;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mode    = MODE_LOAD;
                div_d   = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (!stall_c) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        mode  = dir_q ? MODE_RIGHT : MODE_LEFT;
                        bit_d = CNT_W'(bit_q + 1'b1);
                        if (bit_q == BIT_LAST) begin
                            state_d = DONE;
                        end
                    end else begin
                        div_d = DIV_W'(div_q + 1'b1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign prl_out = prl_q;
    assign bit_cnt = bit_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed words on a DIV=1 and a DIV=3 instance, scoreboard checked on done.
module tb_shift_reg_seq;

    localparam int unsigned SIZE = 8;

    typedef struct {
        logic [7:0] bits;
        int         lat;
        logic [7:0] prl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid [2];
    logic       s_dir   [2];
    logic [7:0] s_data  [2];
    logic       s_ready [2];
    logic       busy    [2];
    logic       done    [2];
    logic [1:0] mode    [2];
    logic [7:0] prl     [2];
    logic [3:0] bcnt    [2];
`ifdef SHIFT_REG_SEQ_PAUSE_EN
    logic       pause   [2];
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] reg_m [2];
    logic [7:0] obits [2];
    int         nsh   [2];
    int         acc   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    shift_reg_seq #(.SIZE(8), .DIV(1)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .s_dir(s_dir[0]),
`ifdef SHIFT_REG_SEQ_PAUSE_EN
        .pause(pause[0]),
`endif
        .mode(mode[0]), .prl_out(prl[0]), .bit_cnt(bcnt[0]), .busy(busy[0]), .done(done[0])
    );

    shift_reg_seq #(.SIZE(8), .DIV(3)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .s_dir(s_dir[1]),
`ifdef SHIFT_REG_SEQ_PAUSE_EN
        .pause(pause[1]),
`endif
        .mode(mode[1]), .prl_out(prl[1]), .bit_cnt(bcnt[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int i, input logic [7:0] bits, input int lat, input logic [7:0] p);
        exp_t e;
        e.bits = bits;
        e.lat  = lat;
        e.prl  = p;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: register model driven by mode/prl_out, scoreboard popped on each done pulse
    task automatic mon(input int i);
        exp_t e;
        if (done[i]) begin
            if (qsize(i) == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done dut%0d: got a done pulse, expected none", i);
            end else begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check("serial_bits", int'(obits[i]), int'(e.bits));
                check("shift_count", nsh[i], SIZE);
                check("done_latency", cyc - acc[i], e.lat);
                check("bit_cnt_at_done", int'(bcnt[i]), SIZE);
                check("prl_out_at_done", int'(prl[i]), int'(e.prl));
            end
        end
        case (mode[i])
            2'b11: begin
                reg_m[i] = prl[i];
                obits[i] = 8'h00;
                nsh[i]   = 0;
            end
            2'b01: begin
                obits[i] = {obits[i][6:0], reg_m[i][7]};
                reg_m[i] = {reg_m[i][6:0], 1'b0};
                nsh[i]++;
            end
            2'b10: begin
                obits[i] = {obits[i][6:0], reg_m[i][0]};
                reg_m[i] = {1'b0, reg_m[i][7:1]};
                nsh[i]++;
            end
            default: ;
        endcase
        if (s_valid[i] && s_ready[i]) acc[i] = cyc;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [7:0] data, input logic dir);
        check("ready_before_send", int'(s_ready[i]), 1);
        s_valid[i] = 1'b1;
        s_data[i]  = data;
        s_dir[i]   = dir;
        tick();
        s_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i, input int max);
        int n = 0;
        while (qsize(i) != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_pending_words", qsize(i), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            s_dir[i]   = 1'b0;
            s_data[i]  = 8'h00;
            reg_m[i]   = 8'h00;
            obits[i]   = 8'h00;
            nsh[i]     = 0;
            acc[i]     = 0;
`ifdef SHIFT_REG_SEQ_PAUSE_EN
            pause[i]   = 1'b0;
`endif
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_s_ready", int'(s_ready[i]), 1);
            check("reset_busy", int'(busy[i]), 0);
            check("reset_mode", int'(mode[i]), 0);
            check("reset_done", int'(done[i]), 0);
            check("reset_bit_cnt", int'(bcnt[i]), 0);
            check("reset_prl_out", int'(prl[i]), 0);
        end
        rst = 1'b0;
        tick();

        // A5 left, DIV=1: LOAD, 8 shift cycles, done in cycle 10
        push(0, 8'hA5, 10, 8'hA5);
        send(0, 8'hA5, 1'b0);
        check("t1_load_mode", int'(mode[0]), 3);
        check("t1_load_busy", int'(busy[0]), 1);
        check("t1_load_ready", int'(s_ready[0]), 0);
        check("t1_prl", int'(prl[0]), 8'hA5);
        for (int k = 2; k <= 9; k++) begin
            tick();
            check("t1_shift_mode", int'(mode[0]), 1);
            check("t1_bit_cnt", int'(bcnt[0]), k - 2);
        end
        tick();
        check("t1_done_mode", int'(mode[0]), 0);
        check("t1_done_busy", int'(busy[0]), 1);
        check("t1_done_ready", int'(s_ready[0]), 0);
        tick();
        check("t1_idle_busy", int'(busy[0]), 0);
        check("t1_idle_ready", int'(s_ready[0]), 1);
        check("t1_prl_hold", int'(prl[0]), 8'hA5);
        drain(0, 5);

        // 3C right, DIV=3: 00,00,10 per bit, done in cycle 26
        push(1, 8'h3C, 26, 8'h3C);
        send(1, 8'h3C, 1'b1);
        check("t2_load_mode", int'(mode[1]), 3);
        for (int j = 0; j < 24; j++) begin
            tick();
            check("t2_shift_mode", int'(mode[1]), (j % 3 == 2) ? 2 : 0);
            check("t2_bit_cnt", int'(bcnt[1]), j / 3);
        end
        tick();
        check("t2_done_bit_cnt", int'(bcnt[1]), 8);
        check("t2_done_mode", int'(mode[1]), 0);
        drain(1, 5);

        // Held s_valid: 11 then 22, second accepted in first IDLE cycle
        push(0, 8'h11, 10, 8'h11);
        push(0, 8'h22, 10, 8'h22);
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h11;
        s_dir[0]   = 1'b0;
        tick();
        s_data[0]  = 8'h22;
        for (int k = 1; k <= 10; k++) begin
            check("t3_prl_busy", int'(prl[0]), 8'h11);
            tick();
        end
        check("t3_idle_ready", int'(s_ready[0]), 1);
        tick();
        s_valid[0] = 1'b0;
        check("t3_second_prl", int'(prl[0]), 8'h22);
        check("t3_second_load", int'(mode[0]), 3);
        drain(0, 15);

        // Async reset after 3 shifts: word abandoned, no done
        send(0, 8'h5A, 1'b0);
        repeat (4) tick();
        check("t4_pre_reset_bit_cnt", int'(bcnt[0]), 3);
        #2 rst = 1'b1;
        #1;
        check("t4_reset_mode", int'(mode[0]), 0);
        check("t4_reset_bit_cnt", int'(bcnt[0]), 0);
        check("t4_reset_busy", int'(busy[0]), 0);
        check("t4_reset_done", int'(done[0]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t4_ready_after_reset", int'(s_ready[0]), 1);
        tick();
        push(0, 8'hC3, 10, 8'hC3);
        send(0, 8'hC3, 1'b1);
        drain(0, 15);

        // s_valid pulsed during SHIFT is ignored
        push(0, 8'h69, 10, 8'h96);
        send(0, 8'h96, 1'b1);
        repeat (3) tick();
        s_valid[0] = 1'b1;
        s_data[0]  = 8'hFF;
        s_dir[0]   = 1'b0;
        tick();
        s_valid[0] = 1'b0;
        check("t5_prl_kept", int'(prl[0]), 8'h96);
        drain(0, 15);
        repeat (5) tick();
        check("t5_idle_after", int'(busy[0]), 0);

`ifdef SHIFT_REG_SEQ_PAUSE_EN
        // Pause for 5 cycles after the 4th shift delays done by 5
        push(0, 8'hA5, 15, 8'hA5);
        send(0, 8'hA5, 1'b0);
        repeat (4) tick();
        tick();
        pause[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t6_pause_mode", int'(mode[0]), 0);
            check("t6_pause_bit_cnt", int'(bcnt[0]), 4);
            tick();
        end
        pause[0] = 1'b0;
        drain(0, 15);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
